fpmul_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 4-stage `fp32_mult_pipelined` instance among `N_REQ` requesters in the matrix-multiplier datapath. It grants at most one operand pair per cycle, drives the multiplier's `start`/`a`/`b`, and tracks a tag for every in-flight operation. It returns each product, with its overflow/underflow flags, to the requester that issued it. It also provides a flush/drain handshake so the pipeline can be emptied before reconfiguring the datapath.

---
 rtl/fpmul_rr_arbiter_if.sv | 44 ++++
 rtl/fpmul_rr_arbiter.sv | 179 +++++++++++++++++
 tb/tb_fpmul_rr_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpmul_rr_arbiter_if.sv
// fpmul_rr_arbiter_if: request/multiplier/response/flush bundle shared by the
// fp32 multiplier arbiter (slave) and its environment (master).
interface fpmul_rr_arbiter_if #(
  parameter int N_REQ = 4
);
  // requester side
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0][31:0]      req_a;
  logic [N_REQ-1:0][31:0]      req_b;
  // multiplier side
  logic                        mul_start;
  logic [31:0]                 mul_a;
  logic [31:0]                 mul_b;
  logic [31:0]                 mul_result;
  logic                        mul_done;
  logic                        mul_overflow;
  logic                        mul_underflow;
  // responses
  logic [N_REQ-1:0]            rsp_valid;
  logic [31:0]                 rsp_data;
  logic                        rsp_overflow;
  logic                        rsp_underflow;
  // control / status
  logic                        flush_req;
  logic                        flush_done;
  logic                        busy;
  logic                        tag_err;
  logic [N_REQ-1:0][15:0]      grant_cnt;

  modport slave (
    input  req_valid, req_a, req_b, mul_result, mul_done, mul_overflow,
           mul_underflow, flush_req,
    output req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_data,
           rsp_overflow, rsp_underflow, flush_done, busy, tag_err, grant_cnt
  );

  modport master (
    output req_valid, req_a, req_b, mul_result, mul_done, mul_overflow,
           mul_underflow, flush_req,
    input  req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_data,
           rsp_overflow, rsp_underflow, flush_done, busy, tag_err, grant_cnt
  );
endinterface

// File: rtl/fpmul_rr_arbiter.sv
// fpmul_rr_arbiter: round-robin sharing of one pipelined fp32 multiplier among
// N_REQ requesters. Tracks a tag per in-flight op, routes each product back to
// its issuer, and offers a flush/drain handshake.
// Optional macro FPMUL_ARB_STATS_EN: per-requester saturating 16-bit grant
// counters; without it grant_cnt is tied to zero.

`ifdef FPMUL_ARB_STATS_EN
// Per-requester saturating grant counter.
module fpmul_arb_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  output logic [15:0] cnt_o
);
  logic [15:0] cnt_q, cnt_d;

  // Next count: add one per handshake, stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule
`endif

module fpmul_rr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 4
) (
  input logic               clk,
  input logic               rst_n,
  fpmul_rr_arbiter_if.slave bus
);
  localparam int TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, FLUSHED = 2'd2} state_e;
  typedef struct packed {
    logic          vld;
    logic [TW-1:0] tag;
  } tag_t;

  state_e              state_q, state_d;
  logic [TW-1:0]       last_q, last_d;
  tag_t [MUL_LAT-1:0]  vld_pipe_q;
  tag_t                push, tail;
  logic                grant_en, found, pipe_vld, rsp_fire, flush_done;
  logic [TW-1:0]       gnt_idx, cand;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    rsp_valid_q;
  logic [31:0]         rsp_data_q;
  logic                rsp_ovf_q, rsp_unf_q, tag_err_q;

  // Round-robin pick: first valid requester after the last handshake.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = TW'((int'(last_q) + k) % N_REQ);
      if (!found && grant_en && bus.req_valid[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign bus.req_ready = gnt;
  assign bus.mul_start = found;
  assign bus.mul_a     = found ? bus.req_a[gnt_idx] : '0;
  assign bus.mul_b     = found ? bus.req_b[gnt_idx] : '0;

  // Fairness pointer moves only on an actual handshake.
  always_comb begin
    last_d = last_q;
    if (found) last_d = gnt_idx;
  end

  // Fairness pointer register; reset lets requester 0 win first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= TW'(N_REQ - 1);
    else        last_q <= last_d;
  end

  assign push.vld = found;
  assign push.tag = found ? gnt_idx : '0;
  assign tail     = vld_pipe_q[MUL_LAT-1];

  // Tag pipe mirrors the multiplier depth; the tail lines up with mul_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= push;
      for (int i = 1; i < MUL_LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
    end
  end

  // Any op still inside the multiplier.
  always_comb begin
    pipe_vld = 1'b0;
    for (int i = 0; i < MUL_LAT; i++) pipe_vld = pipe_vld | vld_pipe_q[i].vld;
  end

  // A response is only produced when done and tag agree.
  assign rsp_fire = bus.mul_done & tail.vld;

  // Response register plus sticky done/tag mismatch flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_unf_q   <= 1'b0;
      tag_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_fire ? (N_REQ'(1) << tail.tag) : '0;
      rsp_data_q  <= rsp_fire ? bus.mul_result : '0;
      rsp_ovf_q   <= rsp_fire & bus.mul_overflow;
      rsp_unf_q   <= rsp_fire & bus.mul_underflow;
      if (bus.mul_done != tail.vld) tag_err_q <= 1'b1;
    end
  end

  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_overflow  = rsp_ovf_q;
  assign bus.rsp_underflow = rsp_unf_q;
  assign bus.tag_err       = tag_err_q;
  assign bus.busy          = pipe_vld | (|rsp_valid_q);

  // Flush FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Flush FSM next state; a drain always completes through FLUSHED.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.flush_req) state_d = DRAIN;
      DRAIN:   if (!pipe_vld && !(|rsp_valid_q)) state_d = FLUSHED;
      FLUSHED: if (!bus.flush_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Flush FSM outputs; flush_req gates grants in the same cycle.
  always_comb begin
    grant_en   = (state_q == RUN) && !bus.flush_req;
    flush_done = (state_q == FLUSHED);
  end

  assign bus.flush_done = flush_done;

`ifdef FPMUL_ARB_STATS_EN
  logic [N_REQ-1:0][15:0] cnt;
  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    fpmul_arb_cnt u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (gnt[g]),
      .cnt_o (cnt[g])
    );
  end
  assign bus.grant_cnt = cnt;
`else
  assign bus.grant_cnt = '0;
`endif
endmodule

// File: tb/tb_fpmul_rr_arbiter.sv
// tb_fpmul_rr_arbiter: table-driven grant vectors, directed latency/flush/
// tag-error/reset sequences, and randomized traffic against a queue-based
// reference model. The bench also plays the 4-stage multiplier.
module tb_fpmul_rr_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic force_done = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpmul_rr_arbiter_if #(.N_REQ(N)) bus ();

  fpmul_rr_arbiter #(.N_REQ(N), .MUL_LAT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Truncating fp32 multiply for normal operands: {ovf, unf, result}.
  function automatic logic [33:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e;
    logic [47:0] p;
    logic [22:0] m;
    s = a[31] ^ b[31];
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    if (p[47]) begin m = p[46:24]; e = e + 1; end
    else       m = p[45:23];
    if (e >= 255) return {1'b1, 1'b0, s, 8'hFF, 23'd0};
    if (e <= 0)   return {1'b0, 1'b1, s, 31'd0};
    return {2'b00, s, e[7:0], m};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    e = 8'($urandom_range(1, 254));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // Multiplier model: 4 cycles from sampled start to done.
  logic [3:0]        mp_v;
  logic [3:0][33:0]  mp_r;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mp_v <= '0;
      mp_r <= '0;
    end else begin
      mp_v <= {mp_v[2:0], bus.mul_start};
      mp_r <= {mp_r[2:0], fmul(bus.mul_a, bus.mul_b)};
    end
  end
  assign bus.mul_done      = mp_v[3] | force_done;
  assign bus.mul_result    = mp_r[3][31:0];
  assign bus.mul_overflow  = mp_r[3][33];
  assign bus.mul_underflow = mp_r[3][32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected responses in issue order plus flush mode.
  typedef struct {
    int          tag;
    logic [31:0] a;
    logic [31:0] b;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          m_last = N - 1;
  int          m_state = 0;   // 0 running, 1 draining, 2 flushed
  int          m_cnt[N];
  logic [N-1:0] m_rdy;
  bit          m_got, m_busy;
  int          m_j;
  exp_t        m_e;
  logic [33:0] m_r;
  logic [N-1:0][15:0] m_gc;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      m_busy = (q.size() != 0);
      m_rdy  = '0;
      m_got  = 1'b0;
      m_j    = 0;
      if (m_state == 0 && !bus.flush_req) begin
        for (int k = 1; k <= N; k++) begin
          if (!m_got && bus.req_valid[(m_last + k) % N]) begin
            m_got = 1'b1;
            m_j   = (m_last + k) % N;
            m_rdy[m_j] = 1'b1;
          end
        end
      end
      check("req_ready", 64'(bus.req_ready), 64'(m_rdy));
      check("mul_start", 64'(bus.mul_start), 64'(m_got));
      check("mul_a", 64'(bus.mul_a), m_got ? 64'(bus.req_a[m_j]) : 64'd0);
      check("mul_b", 64'(bus.mul_b), m_got ? 64'(bus.req_b[m_j]) : 64'd0);
      if (q.size() != 0 && q[0].due == cyc) begin
        m_e = q.pop_front();
        m_r = fmul(m_e.a, m_e.b);
        check("rsp_valid", 64'(bus.rsp_valid), 64'(1) << m_e.tag);
        check("rsp_data", 64'(bus.rsp_data), 64'(m_r[31:0]));
        check("rsp_overflow", 64'(bus.rsp_overflow), 64'(m_r[33]));
        check("rsp_underflow", 64'(bus.rsp_underflow), 64'(m_r[32]));
      end else begin
        check("rsp_idle", 64'(bus.rsp_valid), 64'd0);
      end
      check("busy", 64'(bus.busy), 64'(m_busy));
      check("flush_done", 64'(bus.flush_done), 64'(m_state == 2));
      check("tag_err_clean", 64'(bus.tag_err), 64'd0);
`ifdef FPMUL_ARB_STATS_EN
      for (int i = 0; i < N; i++) m_gc[i] = (m_cnt[i] > 65535) ? 16'hFFFF : 16'(m_cnt[i]);
      check("grant_cnt", 64'(bus.grant_cnt), 64'(m_gc));
`else
      m_gc = '0;
      check("grant_cnt_zero", 64'(bus.grant_cnt), 64'(m_gc));
`endif
      if (m_got) begin
        q.push_back('{tag: m_j, a: bus.req_a[m_j], b: bus.req_b[m_j], due: cyc + 5});
        m_last = m_j;
        m_cnt[m_j]++;
      end
      case (m_state)
        0: if (bus.flush_req) m_state = 1;
        1: if (!m_busy) m_state = 2;
        2: if (!bus.flush_req) m_state = 0;
        default: m_state = 0;
      endcase
    end
  end

  task automatic do_reset();
    mon_en        = 1'b0;
    bus.req_valid = '0;
    bus.flush_req = 1'b0;
    force_done    = 1'b0;
    rst_n         = 1'b0;
    tick();
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_mul_start", 64'(bus.mul_start), 64'd0);
    check("rst_mul_a", 64'(bus.mul_a), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    check("rst_flush_done", 64'(bus.flush_done), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_tag_err", 64'(bus.tag_err), 64'd0);
    check("rst_grant_cnt", 64'(bus.grant_cnt), 64'd0);
    tick();
    rst_n   = 1'b1;
    q.delete();
    m_last  = N - 1;
    m_state = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    mon_en  = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] ready;
  } vec_t;

  vec_t tbl[14];

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : main
    int   t0;
    bit   got;
    tbl[0]  = '{4'b1111, 4'b0001}; tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100}; tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b1010, 4'b0010}; tbl[5]  = '{4'b1010, 4'b1000};
    tbl[6]  = '{4'b1010, 4'b0010}; tbl[7]  = '{4'b1010, 4'b1000};
    tbl[8]  = '{4'b0000, 4'b0000}; tbl[9]  = '{4'b0001, 4'b0001};
    tbl[10] = '{4'b0101, 4'b0100}; tbl[11] = '{4'b0111, 4'b0001};
    tbl[12] = '{4'b0110, 4'b0010}; tbl[13] = '{4'b1001, 4'b1000};

    bus.req_a = '0;
    bus.req_b = '0;
    do_reset();

    // Grant-order vectors; responses are checked by the model.
    for (int i = 0; i < 14; i++) begin
      for (int r = 0; r < N; r++) begin
        bus.req_a[r] = rnd_fp();
        bus.req_b[r] = rnd_fp();
      end
      bus.req_valid = tbl[i].valid;
      @(negedge clk);
      check($sformatf("tbl_ready[%0d]", i), 64'(bus.req_ready), 64'(tbl[i].ready));
      tick();
    end
    bus.req_valid = '0;
    repeat (8) tick();

    // Single request, fixed operands, exact latency.
    bus.req_valid = 4'b0100;
    bus.req_a[2]  = 32'h3FC00000;
    bus.req_b[2]  = 32'h40000000;
    t0 = cyc;
    @(negedge clk);
    check("single_ready", 64'(bus.req_ready), 64'h4);
    tick();
    bus.req_valid = '0;
    while (cyc < t0 + 4) tick();
    @(negedge clk);
    check("single_early", 64'(bus.rsp_valid), 64'd0);
    tick();
    @(negedge clk);
    check("single_rsp_valid", 64'(bus.rsp_valid), 64'h4);
    check("single_rsp_data", 64'(bus.rsp_data), 64'h40400000);
    check("single_flags", 64'({bus.rsp_overflow, bus.rsp_underflow}), 64'd0);
    repeat (3) tick();

    // Flush on an empty pipe: flush_done two cycles later.
    bus.flush_req = 1'b1;
    @(negedge clk);
    check("flush_empty_t0", 64'(bus.flush_done), 64'd0);
    tick();
    @(negedge clk);
    check("flush_empty_t1", 64'(bus.flush_done), 64'd0);
    tick();
    @(negedge clk);
    check("flush_empty_t2", 64'(bus.flush_done), 64'd1);
    tick();
    bus.flush_req = 1'b0;
    tick();

    // Flush with three ops in flight, then resume.
    bus.req_valid = 4'b1111;
    repeat (3) tick();
    bus.flush_req = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.busy) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("flush_busy_fall", 64'(got), 64'd1);
    tick();
    bus.flush_req = 1'b0;
    @(negedge clk);
    check("flush_done_set", 64'(bus.flush_done), 64'd1);
    check("flush_no_grant", 64'(bus.req_ready), 64'd0);
    tick();
    @(negedge clk);
    check("flush_resume", 64'(|bus.req_ready), 64'd1);
    tick();
    bus.req_valid = '0;
    repeat (8) tick();

    // Flush raised for one cycle while busy: drain still completes.
    bus.req_valid = 4'b0011;
    repeat (2) tick();
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    repeat (10) tick();
    bus.req_valid = '0;
    repeat (8) tick();

    // Randomized traffic with occasional flush toggling.
    for (int c = 0; c < 400; c++) begin
      bus.req_valid = N'($urandom);
      for (int r = 0; r < N; r++) begin
        bus.req_a[r] = rnd_fp();
        bus.req_b[r] = rnd_fp();
      end
      if ($urandom_range(0, 15) == 0) bus.flush_req = ~bus.flush_req;
      tick();
    end
    bus.req_valid = '0;
    bus.flush_req = 1'b0;
    repeat (10) tick();

    // Reset with ops in flight: nothing may come out afterwards.
    bus.req_valid = 4'b1111;
    repeat (3) tick();
    do_reset();
    repeat (10) tick();

    // Spurious mul_done: sticky tag_err, no response.
    mon_en = 1'b0;
    repeat (2) tick();
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    @(negedge clk);
    check("tag_err_set", 64'(bus.tag_err), 64'd1);
    check("tag_err_no_rsp", 64'(bus.rsp_valid), 64'd0);
    repeat (5) tick();
    @(negedge clk);
    check("tag_err_sticky", 64'(bus.tag_err), 64'd1);
    do_reset();
    @(negedge clk);
    check("tag_err_cleared", 64'(bus.tag_err), 64'd0);
    tick();

`ifdef FPMUL_ARB_STATS_EN
    // Saturation of requester 0's grant counter.
    bus.req_valid = 4'b0001;
    repeat (70000) tick();
    bus.req_valid = '0;
    @(negedge clk);
    check("grant_cnt_sat", 64'(bus.grant_cnt[0]), 64'hFFFF);
    repeat (8) tick();
`else
    @(negedge clk);
    check("grant_cnt_off", 64'(bus.grant_cnt), 64'd0);
`endif

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
